// File: rtl/mult_inversion_arbiter.sv
// Round-robin arbiter sharing one GF(2^8) inverter between N_REQ byte requesters.
// Packets lock the inverter until their last byte; a tag pipeline routes results back.
module mult_inversion_arbiter #(
    parameter int NB_BYTE     = 8,
    parameter int N_REQ       = 4,
    parameter int INV_LATENCY = 2,
    parameter int NB_ID       = 2
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [N_REQ-1:0]                   i_req_valid,
    input  logic [N_REQ-1:0]                   i_req_last,
    input  logic [N_REQ*NB_BYTE-1:0]           i_req_data,
    output logic [N_REQ-1:0]                   o_req_ready,
    output logic [NB_BYTE-1:0]                 o_inv_data,
    input  logic [NB_BYTE-1:0]                 i_inv_result,
    output logic [N_REQ-1:0]                   o_rsp_valid,
    output logic [NB_ID-1:0]                   o_rsp_id,
    output logic [NB_BYTE-1:0]                 o_rsp_data,
    output logic [$clog2(INV_LATENCY+1)-1:0]   o_inflight,
    output logic                               o_locked
);

    localparam int                NB_INF  = $clog2(INV_LATENCY + 1);
    localparam logic [NB_ID:0]    N_REQ_W = (NB_ID + 1)'(N_REQ);
    localparam logic [NB_ID-1:0]  LAST_ID = NB_ID'(N_REQ - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_ID-1:0]       owner_q, owner_d;
    logic [NB_ID-1:0]       rr_ptr_q, rr_ptr_d;
    logic [INV_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [NB_ID-1:0]       tag_id_q [INV_LATENCY];
    logic [NB_ID-1:0]       tag_id_d [INV_LATENCY];

    logic [N_REQ-1:0]       grant;
    logic [NB_ID-1:0]       grant_id;
    logic [NB_ID-1:0]       next_ptr;
    logic                   found;
    logic [NB_ID:0]         scan;
    logic [NB_ID-1:0]       scan_id;
    logic                   xfer;
    logic                   xfer_last;
    logic [NB_BYTE-1:0]     inv_data;
    logic                   last_vld;
    logic [NB_ID-1:0]       last_id;
    logic [NB_INF-1:0]      inflight;

    // Grant: fixed owner while locked, else first valid requester from rr_ptr upward.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan     = '0;
        scan_id  = '0;
        if (state_q == LOCKED) begin
            grant[owner_q] = 1'b1;
            grant_id       = owner_q;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                scan = {1'b0, rr_ptr_q} + (NB_ID + 1)'(i);
                if (scan >= N_REQ_W) begin
                    scan = scan - N_REQ_W;
                end
                scan_id = scan[NB_ID-1:0];
                if (!found && i_req_valid[scan_id]) begin
                    found          = 1'b1;
                    grant[scan_id] = 1'b1;
                    grant_id       = scan_id;
                end
            end
        end
    end

    always_comb begin
        xfer      = |(i_req_valid & grant);
        xfer_last = |(i_req_valid & i_req_last & grant);
        next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        inv_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k] && i_req_valid[k]) begin
                inv_data = i_req_data[k*NB_BYTE +: NB_BYTE];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (xfer_last) begin
                        rr_ptr_d = next_ptr;
                    end else begin
                        state_d = LOCKED;
                        owner_d = grant_id;
                    end
                end
            end
            LOCKED: begin
                if (xfer && xfer_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
        endcase
    end

    // Tags shift every cycle in lockstep with the inverter's own pipeline.
    always_comb begin
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = grant_id;
        for (int i = 1; i < INV_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < INV_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            for (int i = 0; i < INV_LATENCY; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    always_comb begin
        last_vld = tag_vld_q[INV_LATENCY-1];
        last_id  = tag_id_q[INV_LATENCY-1];
        for (int k = 0; k < N_REQ; k++) begin
            o_rsp_valid[k] = last_vld && (last_id == NB_ID'(k));
        end
        inflight = '0;
        for (int i = 0; i < INV_LATENCY; i++) begin
            inflight = inflight + NB_INF'(tag_vld_q[i]);
        end
    end

    assign o_req_ready = grant;
    assign o_inv_data  = inv_data;
    assign o_rsp_id    = last_id;
    assign o_rsp_data  = last_vld ? i_inv_result : '0;
    assign o_inflight  = inflight;
    assign o_locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_mult_inversion_arbiter.sv
// Bench for mult_inversion_arbiter: directed scenarios then random traffic,
// all cycles checked against a cycle-indexed reference model and a GF(2^8) inverter model.
module tb_mult_inversion_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  v = '0;
    logic [3:0]  l = '0;
    logic [7:0]  d [4];
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  inv_data;
    logic [7:0]  inv_res;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [1:0]  inflight;
    logic        locked;
    logic [7:0]  s1 = '0;
    logic [7:0]  s2 = '0;

    int checks = 0;
    int errors = 0;

    bit         m_locked = 1'b0;
    int         m_owner  = 0;
    int         m_rr     = 0;
    int         cyc      = 0;
    int         base     = 0;
    bit         acc_v  [2048];
    int         acc_id [2048];
    logic [7:0] acc_d  [2048];

    mult_inversion_arbiter dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req_valid  (v),
        .i_req_last   (l),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_inv_data   (inv_data),
        .i_inv_result (inv_res),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_data   (rsp_data),
        .o_inflight   (inflight),
        .o_locked     (locked)
    );

    always #5 clk = ~clk;

    always_comb req_data = {d[3], d[2], d[1], d[0]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = '0;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) r = 8'(x);
        end
        return r;
    endfunction

    // Inverter with two-cycle latency; not reset, like the real one.
    always @(posedge clk) begin
        s1 <= inv_data;
        s2 <= s1;
    end
    always_comb inv_res = gf_inv(s2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic settle();
        int         g;
        int         k;
        int         t;
        int         inf;
        logic [3:0] er;
        logic [7:0] ei;
        @(negedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_rr     = 0;
        end
        g  = -1;
        er = '0;
        if (m_locked) begin
            er[m_owner] = 1'b1;
            if (v[m_owner]) g = m_owner;
        end else begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (g < 0 && v[k]) begin
                    g     = k;
                    er[k] = 1'b1;
                end
            end
        end
        ei = (g >= 0) ? d[g] : 8'h00;
        inf = 0;
        if (!rst) begin
            for (int j = 1; j <= 2; j++) begin
                t = cyc - j;
                if (t >= base && acc_v[t]) inf++;
            end
        end
        check("ready", 32'(req_ready), 32'(er));
        check("inv_data", 32'(inv_data), 32'(ei));
        check("locked", 32'(locked), 32'(m_locked));
        check("inflight", 32'(inflight), inf);
        t = cyc - 2;
        if (!rst && t >= base && acc_v[t]) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1 << acc_id[t]);
            check("rsp_data", 32'(rsp_data), 32'(gf_inv(acc_d[t])));
            check("rsp_id", 32'(rsp_id), acc_id[t]);
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 0);
            check("rsp_data_idle", 32'(rsp_data), 0);
        end
        if (rst) begin
            base        = cyc + 1;
            acc_v[cyc]  = 1'b0;
        end else begin
            acc_v[cyc] = (g >= 0);
            if (g >= 0) begin
                acc_id[cyc] = g;
                acc_d[cyc]  = d[g];
                if (!m_locked && !l[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end else if (l[g]) begin
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % N;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    initial begin
        logic [7:0] exp_rr [4];
        exp_rr[0] = 8'h01;
        exp_rr[1] = 8'h00;
        exp_rr[2] = 8'hCA;
        exp_rr[3] = 8'h53;
        for (int k = 0; k < N; k++) d[k] = '0;

        // reset state
        rst = 1'b1;
        settle();
        check("rst_id", 32'(rsp_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        adv();
        rst = 1'b0;
        settle();
        check("rst_id_after", 32'(rsp_id), 0);
        check("rst_locked", 32'(locked), 0);
        adv();

        // single byte
        v = 4'b0001; l = 4'b0001; d[0] = 8'h53;
        settle();
        check("t1_ready", 32'(req_ready), 1);
        adv();
        v = '0;
        settle();
        check("t1_inf_a", 32'(inflight), 1);
        adv();
        settle();
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_data", 32'(rsp_data), 32'hCA);
        check("t1_inf_b", 32'(inflight), 1);
        adv();
        settle();
        check("t1_inf_c", 32'(inflight), 0);
        adv();

        // round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d[0] = 8'h01; d[1] = 8'h00; d[2] = 8'h53; d[3] = 8'hCA;
        l = 4'hF;
        for (int i = 0; i < 6; i++) begin
            v = (i < 4) ? 4'(4'hF << i) : 4'h0;
            settle();
            if (i < 4) check("rr_grant", 32'(req_ready), 32'd1 << i);
            if (i >= 2) begin
                check("rr_rsp_data", 32'(rsp_data), 32'(exp_rr[i-2]));
                check("rr_rsp_id", 32'(rsp_id), i - 2);
            end
            adv();
        end

        // packet lock with a three-cycle owner bubble
        v = 4'b0100; l = 4'b0000; d[2] = 8'h10;
        settle();
        check("pk_b1", 32'(req_ready), 32'h4);
        adv();
        v = 4'b0101; l = 4'b0001; d[0] = 8'h77; d[2] = 8'h11;
        settle();
        check("pk_b2", 32'(req_ready), 32'h4);
        check("pk_lock2", 32'(locked), 1);
        adv();
        v = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bub_ready", 32'(req_ready), 32'h4);
            check("bub_data", 32'(inv_data), 0);
            check("bub_lock", 32'(locked), 1);
            adv();
        end
        v = 4'b0101; d[2] = 8'h12;
        settle();
        check("pk_b3", 32'(req_ready), 32'h4);
        adv();
        l = 4'b0101; d[2] = 8'h13;
        settle();
        check("pk_b4", 32'(req_ready), 32'h4);
        check("pk_lock4", 32'(locked), 1);
        adv();
        v = 4'b0001;
        settle();
        check("pk_next", 32'(req_ready), 32'h1);
        check("pk_next_data", 32'(inv_data), 32'h77);
        check("pk_unlock", 32'(locked), 0);
        adv();

        // wrap-around: pointer moved to 3 by a single byte from requester 2
        v = 4'b0100; l = 4'b0100; d[2] = 8'h21;
        tick();
        v = 4'b1010; l = 4'b1010; d[1] = 8'h31; d[3] = 8'h33;
        settle();
        check("wrap_first", 32'(req_ready), 32'h8);
        adv();
        v = 4'b0010;
        settle();
        check("wrap_second", 32'(req_ready), 32'h2);
        adv();

        // reset with two bytes in flight
        v = 4'b0010; l = 4'b0010; d[1] = 8'h5A;
        tick();
        d[1] = 8'hA5;
        tick();
        v = '0;
        rst = 1'b1;
        settle();
        check("rif_inflight", 32'(inflight), 0);
        check("rif_rsp", 32'(rsp_valid), 0);
        adv();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        v = 4'hF; l = 4'hF;
        settle();
        check("rif_resume", 32'(req_ready), 32'h1);
        adv();
        v = '0;
        for (int i = 0; i < 3; i++) tick();

        // random traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            v   = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                l[k] = ($urandom_range(0, 2) == 0);
                d[k] = 8'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        v   = '0;
        for (int i = 0; i < 4; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_inversion_arbiter.md
# mult_inversion_arbiter

Round-robin arbiter and sequencer that shares one `multiplicative_inversion` GF(2^8) inverter between N_REQ byte requesters, such as the round SubBytes lanes and the key-expansion SubWord.
- Accepts bytes through per-requester valid/ready handshakes and feeds the inverter one byte per cycle.
- Tracks the owner of each byte through the inverter's fixed pipeline latency and returns each result to the requester that issued it.
- Supports packet locking: a requester keeps the inverter until its last byte, so multi-byte words (e.g. a 4-byte SubWord) stay contiguous.

## Interface
- NB_BYTE, 8, data width; only 8 is supported.
- N_REQ, 4, number of requesters; range 2..8.
- INV_LATENCY, 2, inverter input-to-output latency in cycles. Must be 2 when the inverter has CREATE_OUTPUT_REG=0, and 3 when it has CREATE_OUTPUT_REG=1.
- NB_ID, 2, requester-id width; must equal ceil(log2(N_REQ)).

- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  N_REQ  per-requester byte valid.
- i_req_last  in  N_REQ  per-requester last-byte-of-packet flag; qualified by i_req_valid.
- i_req_data  in  N_REQ*NB_BYTE  per-requester byte; requester k uses bits [k*NB_BYTE +: NB_BYTE].
- o_req_ready  out  N_REQ  per-requester ready; at most one bit set.
- o_inv_data  out  NB_BYTE  to inverter i_data.
- i_inv_result  in  NB_BYTE  from inverter o_mult_inverse.
- o_rsp_valid  out  N_REQ  one-hot result strobe; no backpressure.
- o_rsp_id  out  NB_ID  owner of the current result.
- o_rsp_data  out  NB_BYTE  inverse byte.
- o_inflight  out  ceil(log2(INV_LATENCY+1))  number of bytes currently inside the inverter.
- o_locked  out  1  high while a packet owns the inverter.

## Operation
- **State machine:** two states, IDLE and LOCKED, plus an owner register (NB_ID) and a round-robin pointer rr_ptr (NB_ID).
- **IDLE grant:** o_req_ready is the combinational one-hot grant to the first requester with i_req_valid set, searching from rr_ptr upward with wrap-around. With no request, o_req_ready = 0.
- **LOCKED grant:** o_req_ready[owner] = 1 regardless of i_req_valid[owner]; all other bits are 0.
  - Cycles where the owner is idle pass no byte, and other requesters stay blocked.
- **Transfer:** a transfer occurs when i_req_valid[k] & o_req_ready[k].
  - o_inv_data = i_req_data[k] on a transfer cycle, and 0x00 otherwise.
- **Transitions:**
  - IDLE, transfer with last=0 → LOCKED, owner = k.
  - IDLE, transfer with last=1 → stays IDLE, rr_ptr = (k+1) mod N_REQ.
  - LOCKED, owner transfer with last=1 → IDLE, rr_ptr = (owner+1) mod N_REQ.
  - LOCKED, owner transfer with last=0 → stays LOCKED.
- **Tag pipeline:** INV_LATENCY stages, each holding {valid, id}. Stage 0 loads {transfer, k}; stages shift every cycle with no stall.
- **Response outputs:**
  - o_rsp_valid = onehot(last-stage id) when last-stage valid, else 0.
  - o_rsp_id = last-stage id.
  - o_rsp_data = i_inv_result when o_rsp_valid is nonzero, else 0x00.
- **o_inflight:** population count of the tag-stage valid bits. It must never exceed INV_LATENCY.
- **o_locked:** high exactly in LOCKED.
- **Throughput:** one byte per cycle, sustained across back-to-back packets from different requesters.
  - The last byte of one packet and the first byte of the next can occur on consecutive cycles.
- **Outputs after reset:** o_req_ready as per IDLE with rr_ptr=0, o_inv_data 0x00, o_rsp_valid 0, o_rsp_id 0, o_rsp_data 0x00, o_inflight 0, o_locked 0.
- **Reset mid-operation:**
  - Asynchronously clears the state, owner, rr_ptr and all tag stages.
  - Bytes in flight are dropped; no o_rsp_valid is issued for them, even though the inverter's synchronous registers may still produce data.
  - A packet interrupted by reset is abandoned; the requester must restart it.

## Timing
- Request-to-result latency: a byte accepted on cycle t produces o_rsp_valid on cycle t+INV_LATENCY, i.e. t+2 by default.
- o_req_ready is combinational from i_req_valid in IDLE (same-cycle grant); requesters must not make i_req_valid depend on o_req_ready.
- o_inv_data is combinational from the grant and data mux, feeding the inverter's combinational first stage.
- State, owner and rr_ptr update on the rising edge following the transfer.
- o_rsp_* outputs are combinational from the last tag stage and i_inv_result; there is no extra register.

## Test plan
- **Single byte:** reset, then requester 0 sends 0x53 with last=1 → o_rsp_valid=0001, o_rsp_data=0xCA two cycles later; o_inflight reads 1 for those two cycles, then 0.
- **Round robin:** all 4 requesters hold single-byte requests (0x01, 0x00, 0x53, 0xCA) for 4 cycles → grants in order 0,1,2,3; responses 0x01, 0x00, 0xCA, 0x53 tagged ids 0..3 on consecutive cycles.
- **Packet lock:** requester 2 sends a 4-byte packet with last on byte 4 while requester 0 is continuously valid → requester 0 gets no ready until the cycle after byte 4; o_locked high for bytes 2–4; requester 0's first byte is accepted on the next cycle.
- **Lock bubble:** the owner drops valid for 3 cycles mid-packet → no transfers, o_inv_data=0x00, other requesters blocked, o_locked stays high.
- **Wrap-around:** N_REQ=4, rr_ptr at 3, requesters 1 and 3 valid → 3 is granted first, then 1.
- **Reset in flight:** assert reset one cycle after 2 bytes are accepted → no o_rsp_valid ever appears for those bytes; o_inflight=0 immediately; the arbiter resumes from IDLE with rr_ptr=0.
